// File: rtl/audio_dac_sched.sv
`default_nettype none
// ============================================================================
// Module      : audio_dac_sched
// Description : Sample scheduler / mixer in front of the stereo hybrid
//               PWM/SD DAC. Two signed stereo sources (A = Paula mix,
//               B = auxiliary audio) hand samples over via valid/ready.
//               On every programmable sample tick one sample per source is
//               consumed, the two are mixed with saturation, scaled by a
//               click-free mute/unmute gain ramp and presented to the DAC
//               in offset binary.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1   system clock, single domain
//   reset_n          in   1   asynchronous active-low reset
//   i_tick_div       in  12   sample period = i_tick_div+1 clk cycles
//   i_mute           in   1   1 = ramp to silence and hold, 0 = ramp up, play
//   i_a_valid        in   1   source A sample valid
//   o_a_ready        out  1   source A holding register empty
//   i_a_l, i_a_r     in  16   source A samples, two's complement
//   i_b_valid        in   1   source B sample valid
//   o_b_ready        out  1   source B holding register empty
//   i_b_l, i_b_r     in  16   source B samples, two's complement
//   o_d_l, o_d_r     out 16   DAC inputs, offset binary (16'h8000 = silence)
//   o_sample_strobe  out  1   one-cycle pulse when o_d_l/o_d_r update
//   o_underrun_a/_b  out  1   one-cycle pulse: tick found holding reg empty
//   o_muted          out  1   high while the gain FSM is in MUTED
// ============================================================================
module audio_dac_sched #(
    parameter int RAMP_STEP = 1          // gain step per tick, 1..256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] i_tick_div,
    input  logic        i_mute,
    input  logic        i_a_valid,
    output logic        o_a_ready,
    input  logic [15:0] i_a_l,
    input  logic [15:0] i_a_r,
    input  logic        i_b_valid,
    output logic        o_b_ready,
    input  logic [15:0] i_b_l,
    input  logic [15:0] i_b_r,
    output logic [15:0] o_d_l,
    output logic [15:0] o_d_r,
    output logic        o_sample_strobe,
    output logic        o_underrun_a,
    output logic        o_underrun_b,
    output logic        o_muted
);

    localparam logic [8:0] c_STEP  = 9'(RAMP_STEP);
    localparam logic [8:0] c_UNITY = 9'd256;

    typedef enum logic [1:0] {
        S_MUTED = 2'd0,
        S_UP    = 2'd1,
        S_RUN   = 2'd2,
        S_DOWN  = 2'd3
    } gain_state_t;

    // Signed 16-bit add with clamping to the representable range.
    function automatic logic [15:0] sat_add(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        s = {x[15], x} + {y[15], y};
        if (s[16] != s[15])
            sat_add = s[16] ? 16'h8000 : 16'h7FFF;
        else
            sat_add = s[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Sample tick generator
    // ------------------------------------------------------------------
    // The counter cannot be loaded from i_tick_div inside the asynchronous
    // reset branch, so the first cycle after reset acts as the load cycle:
    // it loads tick_div-1 (the value a reset-time load would have reached
    // one cycle later), or ticks straight away when tick_div is zero.
    logic [11:0] r_tick_cnt;
    logic        r_reload;
    logic        w_tick;

    assign w_tick = r_reload ? (i_tick_div == 12'd0) : (r_tick_cnt == 12'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= 12'd0;
            r_reload   <= 1'b1;
        end else begin
            r_reload <= 1'b0;
            if (w_tick)
                r_tick_cnt <= i_tick_div;
            else if (r_reload)
                r_tick_cnt <= i_tick_div - 12'd1;
            else
                r_tick_cnt <= r_tick_cnt - 12'd1;
        end
    end

    // ------------------------------------------------------------------
    // Source holding registers ({left, right} packed)
    // ------------------------------------------------------------------
    logic [31:0] r_a_hold, r_a_last, r_b_hold, r_b_last;
    logic        r_a_full, r_b_full;
    logic        r_und_a, r_und_b;
    logic        w_a_acc, w_b_acc;
    logic [31:0] w_a_new, w_b_new;

    assign o_a_ready = reset_n & ~r_a_full;
    assign o_b_ready = reset_n & ~r_b_full;
    assign w_a_acc   = i_a_valid & o_a_ready;
    assign w_b_acc   = i_b_valid & o_b_ready;

    // Sample each source contributes on this tick: the fresh one if held,
    // otherwise the previous one is reused.
    assign w_a_new = r_a_full ? r_a_hold : r_a_last;
    assign w_b_new = r_b_full ? r_b_hold : r_b_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_hold <= 32'd0;
            r_a_last <= 32'd0;
            r_a_full <= 1'b0;
            r_b_hold <= 32'd0;
            r_b_last <= 32'd0;
            r_b_full <= 1'b0;
            r_und_a  <= 1'b0;
            r_und_b  <= 1'b0;
        end else begin
            // A full register cannot accept, so consume and accept never
            // collide; an accept on a tick with an empty register is kept
            // for the following tick.
            if (w_tick && r_a_full) begin
                r_a_last <= r_a_hold;
                r_a_full <= 1'b0;
            end else if (w_a_acc) begin
                r_a_hold <= {i_a_l, i_a_r};
                r_a_full <= 1'b1;
            end
            if (w_tick && r_b_full) begin
                r_b_last <= r_b_hold;
                r_b_full <= 1'b0;
            end else if (w_b_acc) begin
                r_b_hold <= {i_b_l, i_b_r};
                r_b_full <= 1'b1;
            end
            r_und_a <= w_tick & ~r_a_full;
            r_und_b <= w_tick & ~r_b_full;
        end
    end

    // ------------------------------------------------------------------
    // Gain FSM (advances on ticks only)
    // ------------------------------------------------------------------
    gain_state_t r_state, w_state_nxt;
    logic [8:0]  r_gain, w_gain_nxt;
    logic [9:0]  w_gain_inc;
    logic [8:0]  w_gain_up, w_gain_dn;

    assign w_gain_inc = {1'b0, r_gain} + {1'b0, c_STEP};
    assign w_gain_up  = (w_gain_inc >= {1'b0, c_UNITY}) ? c_UNITY : w_gain_inc[8:0];
    assign w_gain_dn  = (r_gain <= c_STEP) ? 9'd0 : (r_gain - c_STEP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_MUTED;
            r_gain  <= 9'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        if (w_tick) begin
            case (r_state)
                S_MUTED: begin
                    if (!i_mute)
                        w_state_nxt = S_UP;
                end
                S_UP: begin
                    // Direction reversal costs one tick without a step.
                    if (i_mute) begin
                        w_state_nxt = S_DOWN;
                    end else begin
                        w_gain_nxt = w_gain_up;
                        if (w_gain_up == c_UNITY)
                            w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_mute)
                        w_state_nxt = S_DOWN;
                end
                S_DOWN: begin
                    if (!i_mute) begin
                        w_state_nxt = S_UP;
                    end else begin
                        w_gain_nxt = w_gain_dn;
                        if (w_gain_dn == 9'd0)
                            w_state_nxt = S_MUTED;
                    end
                end
                default: begin
                    w_state_nxt = S_MUTED;
                    w_gain_nxt  = 9'd0;
                end
            endcase
        end
    end

    assign o_muted = (r_state == S_MUTED);

    // ------------------------------------------------------------------
    // Mix / scale / output pipeline (tick at T, strobe at T+3)
    // ------------------------------------------------------------------
    logic [15:0]        r_mix_l, r_mix_r;
    logic [8:0]         r_g1;
    logic               r_v1, r_v2;
    logic [15:0]        r_scaled_l, r_scaled_r;
    logic [15:0]        r_d_l, r_d_r;
    logic               r_strobe;
    logic signed [25:0] w_prod_l, w_prod_r;
    logic [15:0]        w_scaled_l, w_scaled_r;

    // Gain 0..256 is zero-extended so it multiplies as a positive value;
    // the arithmetic shift rounds toward minus infinity, and 256 gives the
    // mix back exactly.
    assign w_prod_l   = $signed({{10{r_mix_l[15]}}, r_mix_l}) * $signed({17'd0, r_g1});
    assign w_prod_r   = $signed({{10{r_mix_r[15]}}, r_mix_r}) * $signed({17'd0, r_g1});
    assign w_scaled_l = 16'(w_prod_l >>> 8);
    assign w_scaled_r = 16'(w_prod_r >>> 8);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mix_l    <= 16'd0;
            r_mix_r    <= 16'd0;
            r_g1       <= 9'd0;
            r_v1       <= 1'b0;
            r_scaled_l <= 16'd0;
            r_scaled_r <= 16'd0;
            r_v2       <= 1'b0;
            r_d_l      <= 16'h8000;
            r_d_r      <= 16'h8000;
            r_strobe   <= 1'b0;
        end else begin
            r_v1 <= w_tick;
            if (w_tick) begin
                r_mix_l <= sat_add(w_a_new[31:16], w_b_new[31:16]);
                r_mix_r <= sat_add(w_a_new[15:0],  w_b_new[15:0]);
                // Gain in force when the tick happened, not the value the
                // FSM moves to on this same edge.
                r_g1    <= r_gain;
            end
            r_v2       <= r_v1;
            r_scaled_l <= w_scaled_l;
            r_scaled_r <= w_scaled_r;
            r_strobe   <= r_v2;
            if (r_v2) begin
                r_d_l <= r_scaled_l ^ 16'h8000;
                r_d_r <= r_scaled_r ^ 16'h8000;
            end
        end
    end

    assign o_d_l           = r_d_l;
    assign o_d_r           = r_d_r;
    assign o_sample_strobe = r_strobe;
    assign o_underrun_a    = r_und_a;
    assign o_underrun_b    = r_und_b;

endmodule
`default_nettype wire

// File: tb/tb_audio_dac_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_dac_sched
// Description : Self-checking bench for audio_dac_sched. Stimulus tasks push
//               the expected DAC word for each sample tick into a queue; a
//               monitor pops and compares whenever the DUT strobes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_audio_dac_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] tick_div;
    logic        mute;
    logic        a_valid, b_valid;
    logic [15:0] a_l, a_r, b_l, b_r;
    logic        a_ready, b_ready;
    logic [15:0] d_l, d_r;
    logic        strobe, und_a, und_b, muted;

    always #5 clk = ~clk;

    audio_dac_sched #(.RAMP_STEP(64)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_tick_div      (tick_div),
        .i_mute          (mute),
        .i_a_valid       (a_valid),
        .o_a_ready       (a_ready),
        .i_a_l           (a_l),
        .i_a_r           (a_r),
        .i_b_valid       (b_valid),
        .o_b_ready       (b_ready),
        .i_b_l           (b_l),
        .i_b_r           (b_r),
        .o_d_l           (d_l),
        .o_d_r           (d_r),
        .o_sample_strobe (strobe),
        .o_underrun_a    (und_a),
        .o_underrun_b    (und_b),
        .o_muted         (muted)
    );

    typedef struct {
        logic [15:0] dl;
        logic [15:0] dr;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    int   tb_cnt = 0;
    int   n_acc  = 0;
    int   seq    = 0;
    bit   auto_a = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_n && strobe) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got l=%h r=%h at cycle %0d, required no strobe", d_l, d_r, cyc_n);
            end else begin
                mon_e = sb.pop_front();
                if (d_l !== mon_e.dl || d_r !== mon_e.dr || cyc_n != mon_e.due) begin
                    errors++;
                    $display("FAIL sample: got l=%h r=%h at cycle %0d, required l=%h r=%h at cycle %0d",
                             d_l, d_r, cyc_n, mon_e.dl, mon_e.dr, mon_e.due);
                end
            end
        end else if (sb.size() > 0 && cyc_n > sb[0].due) begin
            checks++;
            errors++;
            mon_e = sb.pop_front();
            $display("FAIL missing_strobe: none by cycle %0d, required l=%h r=%h at cycle %0d",
                     cyc_n, mon_e.dl, mon_e.dr, mon_e.due);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    // One clock; keeps the bench's own tick counter and accept count.
    task automatic cyc();
        logic acc;
        acc = a_valid && a_ready;
        @(posedge clk);
        #1;
        if (tb_cnt == 0) tb_cnt = int'(tick_div);
        else             tb_cnt = tb_cnt - 1;
        if (acc) begin
            n_acc++;
            if (auto_a) begin
                seq++;
                a_l = 16'((seq + 1) * 256);
                a_r = -a_l;
            end
        end
    endtask

    task automatic push_a(input logic [15:0] l, input logic [15:0] r);
        logic acc;
        int   g;
        acc = 1'b0;
        g = 0;
        a_valid = 1'b1; a_l = l; a_r = r;
        while (!acc && g < 20) begin
            acc = a_ready;
            cyc();
            g++;
        end
        a_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_a_timeout: got no accept, required accept within 20 cycles");
        end
    endtask

    task automatic push_b(input logic [15:0] l, input logic [15:0] r);
        logic acc;
        int   g;
        acc = 1'b0;
        g = 0;
        b_valid = 1'b1; b_l = l; b_r = r;
        while (!acc && g < 20) begin
            acc = b_ready;
            cyc();
            g++;
        end
        b_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_b_timeout: got no accept, required accept within 20 cycles");
        end
    endtask

    // Advance to the next tick, queue its expected DAC word, step past it
    // and check the underrun pulses. cb offers a B sample in the tick cycle.
    task automatic tk(input logic [15:0] dl, input logic [15:0] dr, input logic ua, input logic ub,
                      input bit cb = 1'b0, input logic [15:0] cbl = 16'h0, input logic [15:0] cbr = 16'h0);
        int g;
        g = 0;
        while (tb_cnt != 0 && g < 100) begin
            cyc();
            g++;
        end
        if (tb_cnt != 0) begin
            checks++; errors++;
            $display("FAIL tick_wait: got no tick, required tick within 100 cycles");
        end
        sb.push_back('{dl: dl, dr: dr, due: cyc_n + 3});
        if (cb) begin
            b_valid = 1'b1; b_l = cbl; b_r = cbr;
        end
        cyc();
        if (cb) b_valid = 1'b0;
        chk1("underrun_a", und_a, ua);
        chk1("underrun_b", und_b, ub);
    endtask

    logic [15:0] ramp_l [5] = '{16'h8000, 16'h9000, 16'hA000, 16'hB000, 16'hC000};
    logic [15:0] ramp_r [5] = '{16'h8000, 16'h7000, 16'h6000, 16'h5000, 16'h4000};

    initial begin
        logic [15:0] sl;
        reset_n = 1'b0; tick_div = 12'd3; mute = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_l = 16'h0; a_r = 16'h0; b_l = 16'h0; b_r = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk16("reset_d_l", d_l, 16'h8000);
        chk16("reset_d_r", d_r, 16'h8000);
        chk1("reset_muted", muted, 1'b1);
        chk1("reset_a_ready", a_ready, 1'b0);
        chk1("reset_b_ready", b_ready, 1'b0);
        reset_n = 1'b1;
        tb_cnt  = int'(tick_div);
        cyc();
        chk1("release_a_ready", a_ready, 1'b1);
        chk1("release_b_ready", b_ready, 1'b1);

        // Muted, both sources empty
        tk(16'h8000, 16'h8000, 1'b1, 1'b1);
        chk1("still_muted", muted, 1'b1);

        // Unmute ramp, a = +16384 / -16384, b = 0
        mute = 1'b0;
        push_a(16'h4000, 16'hC000); push_b(16'h0000, 16'h0000);
        tk(16'h8000, 16'h8000, 1'b0, 1'b0);
        chk1("unmuting", muted, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push_a(16'h4000, 16'hC000); push_b(16'h0000, 16'h0000);
            tk(ramp_l[i], ramp_r[i], 1'b0, 1'b0);
        end

        // Saturation at unity gain
        push_a(16'h7000, 16'h8000); push_b(16'h7000, 16'h8000);
        tk(16'hFFFF, 16'h0000, 1'b0, 1'b0);
        push_a(16'h7FFF, 16'h8000); push_b(16'h0001, 16'hFFFF);
        tk(16'hFFFF, 16'h0000, 1'b0, 1'b0);
        push_a(16'h1234, 16'hFFFF); push_b(16'h0100, 16'h0001);
        tk(16'h9334, 16'h8000, 1'b0, 1'b0);

        // Underrun on B: previous B sample reused
        push_a(16'h2000, 16'h2000);
        tk(16'hA100, 16'hA001, 1'b0, 1'b1);
        // B offered in the tick cycle on an empty register
        tk(16'hA100, 16'hA001, 1'b1, 1'b1, 1'b1, 16'h0300, 16'h0300);
        chk1("b_ready_after_coincident", b_ready, 1'b0);
        push_a(16'h0000, 16'h0000);
        tk(16'h8300, 16'h8300, 1'b0, 1'b0);

        // Continuous valid over 10 ticks, period changed to 8 cycles
        tick_div = 12'd7;
        n_acc  = 0;
        seq    = 0;
        auto_a = 1'b1;
        a_valid = 1'b1; a_l = 16'h0100; a_r = 16'hFF00;
        b_valid = 1'b1; b_l = 16'h0000; b_r = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk1("a_ready_until_tick", a_ready, 1'b0);
            if (k == 9) begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
            sl = 16'((k + 1) * 256);
            tk(sl ^ 16'h8000, (-sl) ^ 16'h8000, 1'b0, 1'b0);
        end
        auto_a = 1'b0;
        chk16("accept_count", 16'(n_acc), 16'd10);

        // Ramp down from unity, then mute 1->0->1 mid-ramp
        tick_div = 12'd3;
        mute = 1'b1;
        push_a(16'h4000, 16'hFFFF); push_b(16'h0000, 16'h0000);
        tk(16'hC000, 16'h7FFF, 1'b0, 1'b0);
        chk1("muted_in_down", muted, 1'b0);
        tk(16'hC000, 16'h7FFF, 1'b1, 1'b1);
        tk(16'hB000, 16'h7FFF, 1'b1, 1'b1);
        tk(16'hA000, 16'h7FFF, 1'b1, 1'b1);
        tk(16'h9000, 16'h7FFF, 1'b1, 1'b1);
        chk1("muted_after_down", muted, 1'b1);
        mute = 1'b0;
        tk(16'h8000, 16'h8000, 1'b1, 1'b1);
        tk(16'h8000, 16'h8000, 1'b1, 1'b1);
        tk(16'h9000, 16'h7FFF, 1'b1, 1'b1);
        mute = 1'b1;
        tk(16'hA000, 16'h7FFF, 1'b1, 1'b1);
        tk(16'hA000, 16'h7FFF, 1'b1, 1'b1);
        tk(16'h9000, 16'h7FFF, 1'b1, 1'b1);
        chk1("muted_after_reversal", muted, 1'b1);

        // Reset while ramping up with a sample in flight
        mute = 1'b0;
        tk(16'h8000, 16'h8000, 1'b1, 1'b1);
        tk(16'h8000, 16'h8000, 1'b1, 1'b1);
        tk(16'h9000, 16'h7FFF, 1'b1, 1'b1);
        tk(16'hA000, 16'h7FFF, 1'b1, 1'b1);
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk16("midramp_reset_d_l", d_l, 16'h8000);
        chk16("midramp_reset_d_r", d_r, 16'h8000);
        chk1("midramp_reset_muted", muted, 1'b1);
        chk1("midramp_reset_a_ready", a_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_strobe", strobe, 1'b0);
        reset_n = 1'b1;
        tb_cnt  = int'(tick_div);
        tk(16'h8000, 16'h8000, 1'b1, 1'b1);
        chk1("unmute_after_reset", muted, 1'b0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending samples, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
